// File: rtl/sweep_cfg_loader_if.sv
// +----------------------------------------------------------------------------+
// | Module      : sweep_cfg_loader_if                                          |
// | Description : Request/status bundle between a sweep configuration source   |
// |               and the sweep_cfg_loader front-end.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface sweep_cfg_loader_if;
   // Request side
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_start_hz;
   logic [31:0] cfg_stop_hz;
   logic [31:0] cfg_step_hz;
   // Committed generator configuration
   logic [31:0] start_freq;
   logic [31:0] stop_freq;
   logic [31:0] step_size;
   logic        sweep_rst;
   // Status
   logic        cfg_done;
   logic        cfg_err;
   logic        busy;

   // Configuration source
   modport master (
      output cfg_valid, cfg_start_hz, cfg_stop_hz, cfg_step_hz,
      input  cfg_ready, start_freq, stop_freq, step_size,
      input  sweep_rst, cfg_done, cfg_err, busy
   );

   // Loader
   modport slave (
      input  cfg_valid, cfg_start_hz, cfg_stop_hz, cfg_step_hz,
      output cfg_ready, start_freq, stop_freq, step_size,
      output sweep_rst, cfg_done, cfg_err, busy
   );
endinterface

`default_nettype wire

// File: rtl/sweep_cfg_loader.sv
// +----------------------------------------------------------------------------+
// | Module      : sweep_cfg_loader                                             |
// | Description : Converts a Hz sweep request (start/stop/step) into 32-bit    |
// |               DDS phase increments with a serial shift-add multiplier,     |
// |               validates them and commits all three atomically while       |
// |               holding the sweep generator in reset.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sweep_cfg_loader #(
   parameter logic [31:0] SCALE      = 32'd3655519,
   parameter int          FRAC       = 16,
   parameter int          RST_CYCLES = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   sweep_cfg_loader_if.slave  cfg
);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_CONV        = 2'd1,
      S_CHECK       = 2'd2,
      S_COMMIT_HOLD = 2'd3
   } state_t;

   localparam int                  C_HOLD_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [C_HOLD_W-1:0] C_HOLD_LAST  = C_HOLD_W'(RST_CYCLES - 1);
   localparam logic [63:0]         C_MCAND_INIT = {32'd0, SCALE};

   state_t               state_q, state_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 sweep_rst_q, sweep_rst_d;
   logic [31:0]          start_q, start_d;
   logic [31:0]          stop_q, stop_d;
   logic [31:0]          step_q, step_d;
   // Captured request (Hz)
   logic [31:0]          start_hz_q, start_hz_d;
   logic [31:0]          stop_hz_q, stop_hz_d;
   logic [31:0]          step_hz_q, step_hz_d;
   // Converted increments awaiting validation
   logic [31:0]          sh_start_q, sh_start_d;
   logic [31:0]          sh_stop_q, sh_stop_d;
   logic [31:0]          sh_step_q, sh_step_d;
   // Serial multiplier: accumulator, shifted multiplicand, shifted multiplier
   logic [63:0]          acc_q, acc_d;
   logic [63:0]          mcand_q, mcand_d;
   logic [31:0]          mplier_q, mplier_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [1:0]           idx_q, idx_d;
   logic [C_HOLD_W-1:0]  hold_q, hold_d;

   logic [63:0]          w_acc_next;
   logic [63:0]          w_shift;
   logic [31:0]          w_conv_res;

   // One multiplier iteration, and the scaled/saturated result of the final one
   assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
   assign w_shift    = w_acc_next >> FRAC;
   assign w_conv_res = (|w_shift[63:32]) ? 32'hFFFF_FFFF : w_shift[31:0];

   // Next-state and datapath decode; every register holds unless a state acts on it
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      err_d       = err_q;
      sweep_rst_d = sweep_rst_q;
      start_d     = start_q;
      stop_d      = stop_q;
      step_d      = step_q;
      start_hz_d  = start_hz_q;
      stop_hz_d   = stop_hz_q;
      step_hz_d   = step_hz_q;
      sh_start_d  = sh_start_q;
      sh_stop_d   = sh_stop_q;
      sh_step_d   = sh_step_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      bit_cnt_d   = bit_cnt_q;
      idx_d       = idx_q;
      hold_d      = hold_q;

      case (state_q)
         S_IDLE: begin
            // ready_q is low for the first cycle out of reset, so no capture then
            if (cfg.cfg_valid && ready_q) begin
               start_hz_d = cfg.cfg_start_hz;
               stop_hz_d  = cfg.cfg_stop_hz;
               step_hz_d  = cfg.cfg_step_hz;
               acc_d      = 64'd0;
               mcand_d    = C_MCAND_INIT;
               mplier_d   = cfg.cfg_start_hz;
               bit_cnt_d  = 5'd0;
               idx_d      = 2'd0;
               state_d    = S_CONV;
            end
         end

         S_CONV: begin
            acc_d     = w_acc_next;
            mcand_d   = {mcand_q[62:0], 1'b0};
            mplier_d  = {1'b0, mplier_q[31:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
               // Last iteration of this operand: store it and load the next one
               acc_d   = 64'd0;
               mcand_d = C_MCAND_INIT;
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd0) begin
                  sh_start_d = w_conv_res;
                  mplier_d   = stop_hz_q;
               end else if (idx_q == 2'd1) begin
                  sh_stop_d  = w_conv_res;
                  mplier_d   = step_hz_q;
               end else begin
                  sh_step_d  = w_conv_res;
                  state_d    = S_CHECK;
               end
            end
         end

         S_CHECK: begin
            if ((sh_step_q == 32'd0) || (sh_stop_q < sh_start_q)) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               // All three outputs change together, with the generator in reset
               start_d     = sh_start_q;
               stop_d      = sh_stop_q;
               step_d      = sh_step_q;
               sweep_rst_d = 1'b1;
               hold_d      = '0;
               state_d     = S_COMMIT_HOLD;
            end
         end

         S_COMMIT_HOLD: begin
            if (hold_q == C_HOLD_LAST) begin
               sweep_rst_d = 1'b0;
               err_d       = 1'b0;
               done_d      = 1'b1;
               state_d     = S_IDLE;
            end else begin
               hold_d = hold_q + C_HOLD_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
   end

   // State and datapath registers; reset leaves the generator held in reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         sweep_rst_q <= 1'b1;
         start_q     <= 32'd0;
         stop_q      <= 32'd0;
         step_q      <= 32'd0;
         start_hz_q  <= 32'd0;
         stop_hz_q   <= 32'd0;
         step_hz_q   <= 32'd0;
         sh_start_q  <= 32'd0;
         sh_stop_q   <= 32'd0;
         sh_step_q   <= 32'd0;
         acc_q       <= 64'd0;
         mcand_q     <= 64'd0;
         mplier_q    <= 32'd0;
         bit_cnt_q   <= 5'd0;
         idx_q       <= 2'd0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         err_q       <= err_d;
         sweep_rst_q <= sweep_rst_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         step_q      <= step_d;
         start_hz_q  <= start_hz_d;
         stop_hz_q   <= stop_hz_d;
         step_hz_q   <= step_hz_d;
         sh_start_q  <= sh_start_d;
         sh_stop_q   <= sh_stop_d;
         sh_step_q   <= sh_step_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         bit_cnt_q   <= bit_cnt_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
      end
   end

   assign cfg.cfg_ready  = ready_q;
   assign cfg.busy       = ~ready_q;
   assign cfg.cfg_done   = done_q;
   assign cfg.cfg_err    = err_q;
   assign cfg.sweep_rst  = sweep_rst_q;
   assign cfg.start_freq = start_q;
   assign cfg.stop_freq  = stop_q;
   assign cfg.step_size  = step_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_cfg_loader.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sweep_cfg_loader                                          |
// | Description : Self-checking bench for sweep_cfg_loader: directed cases     |
// |               plus randomized requests against a behavioural model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_sweep_cfg_loader;

   localparam logic [31:0] SCALE      = 32'd3655519;
   localparam int          FRAC       = 16;
   localparam int          RST_CYCLES = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   // Model of the committed state
   logic [31:0] m_start, m_stop, m_step;
   logic        m_rst, m_err;

   sweep_cfg_loader_if ifc ();

   sweep_cfg_loader #(
      .SCALE      (SCALE),
      .FRAC       (FRAC),
      .RST_CYCLES (RST_CYCLES)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .cfg   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hz -> phase increment straight from the arithmetic definition
   function automatic logic [31:0] conv(input logic [31:0] hz);
      logic [63:0] p;
      p = 64'(hz) * 64'(SCALE);
      if ((p >> (FRAC + 32)) != 64'd0) return 32'hFFFF_FFFF;
      return 32'(p >> FRAC);
   endfunction

   function automatic logic [100:0] vec(input logic rdy, input logic dn, input logic er,
                                        input logic sr, input logic [31:0] s,
                                        input logic [31:0] p, input logic [31:0] t);
      return {rdy, ~rdy, dn, er, sr, s, p, t};
   endfunction

   function automatic logic [100:0] obs_vec();
      return {ifc.cfg_ready, ifc.busy, ifc.cfg_done, ifc.cfg_err, ifc.sweep_rst,
              ifc.start_freq, ifc.stop_freq, ifc.step_size};
   endfunction

   // Called at a negedge with the loader idle; checks every cycle up to cfg_done
   task automatic run_req(input logic [31:0] s, input logic [31:0] p,
                          input logic [31:0] t, input bit garbage);
      logic [31:0]  ns, np, nt;
      logic [100:0] expv;
      bit           acc;
      int           d;
      ns  = conv(s);
      np  = conv(p);
      nt  = conv(t);
      acc = (nt != 32'd0) && (np >= ns);
      d   = acc ? 98 + RST_CYCLES : 98;
      check_eq("ready_at_request", 128'(ifc.cfg_ready), 128'(1'b1));
      ifc.cfg_valid    = 1'b1;
      ifc.cfg_start_hz = s;
      ifc.cfg_stop_hz  = p;
      ifc.cfg_step_hz  = t;
      for (int c = 1; c <= d; c++) begin
         @(negedge clk);
         if (c == d)
            expv = vec(1'b1, 1'b1, !acc, acc ? 1'b0 : m_rst,
                       acc ? ns : m_start, acc ? np : m_stop, acc ? nt : m_step);
         else if (acc && c >= 98)
            expv = vec(1'b0, 1'b0, m_err, 1'b1, ns, np, nt);
         else
            expv = vec(1'b0, 1'b0, m_err, m_rst, m_start, m_stop, m_step);
         check_eq($sformatf("cycle%0d", c), 128'(obs_vec()), 128'(expv));
         if (garbage && c < d) begin
            ifc.cfg_valid    = 1'b1;
            ifc.cfg_start_hz = $urandom();
            ifc.cfg_stop_hz  = $urandom();
            ifc.cfg_step_hz  = $urandom();
         end else begin
            ifc.cfg_valid = 1'b0;
         end
      end
      if (acc) begin
         m_start = ns;
         m_stop  = np;
         m_step  = nt;
         m_rst   = 1'b0;
      end
      m_err = !acc;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      check_eq("idle", 128'(obs_vec()),
               128'(vec(1'b1, 1'b0, m_err, m_rst, m_start, m_stop, m_step)));
   endtask

   initial begin
      logic [31:0] s, p, t;
      n_checks = 0;
      n_errors = 0;
      ifc.cfg_valid    = 1'b0;
      ifc.cfg_start_hz = 32'd0;
      ifc.cfg_stop_hz  = 32'd0;
      ifc.cfg_step_hz  = 32'd0;
      m_start = 32'd0; m_stop = 32'd0; m_step = 32'd0; m_rst = 1'b1; m_err = 1'b0;

      // Reset state
      reset = 1'b1;
      #1;
      check_eq("reset_async", 128'(obs_vec()), 128'(vec(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0)));
      repeat (3) @(negedge clk);
      check_eq("reset_held", 128'(obs_vec()), 128'(vec(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0)));
      reset = 1'b0;
      @(negedge clk);
      check_eq("after_release", 128'(obs_vec()), 128'(vec(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0)));

      // Single accepted request
      run_req(32'd16000000, 32'd17000000, 32'd100000, 1'b0);
      check_eq("step_size_ref", 128'(ifc.step_size), 128'(32'h00551C97));
      check_eq("start_freq_ref", 128'(ifc.start_freq),
               128'((64'd16000000 * 64'd3655519) >> 16));
      idle_cycle();

      // Zero step, then stop below start, then a good request clears the error
      run_req(32'd5000000, 32'd6000000, 32'd0, 1'b0);
      idle_cycle();
      run_req(32'd2000000, 32'd1000000, 32'd1000, 1'b0);
      idle_cycle();
      run_req(32'd1000000, 32'd2000000, 32'd1000, 1'b0);
      idle_cycle();

      // Saturation is accepted
      run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check_eq("sat_start", 128'(ifc.start_freq), 128'(32'hFFFF_FFFF));
      idle_cycle();

      // Valid held high with changing inputs while busy
      run_req(32'd3000000, 32'd3500000, 32'd2500, 1'b1);
      idle_cycle();

      // Back-to-back: second request in the first one's cfg_done cycle
      run_req(32'd7000000, 32'd9000000, 32'd50000, 1'b0);
      run_req(32'd10000000, 32'd10000000, 32'd7, 1'b0);
      idle_cycle();

      // Randomized requests
      for (int i = 0; i < 16; i++) begin
         s = $urandom_range(40_000_000, 0);
         case ($urandom_range(3, 0))
            0: begin p = s + $urandom_range(5_000_000, 0); t = $urandom_range(1_000_000, 0); end
            1: begin p = $urandom_range(40_000_000, 0);    t = $urandom_range(1_000_000, 1); end
            2: begin p = s;                                 t = $urandom_range(1, 0);         end
            default: begin s = $urandom(); p = $urandom(); t = $urandom(); end
         endcase
         run_req(s, p, t, 1'($urandom_range(1, 0)));
         if ($urandom_range(1, 0) == 1) idle_cycle();
      end

      // Reset during cycle 50 of conversion discards the request
      ifc.cfg_valid    = 1'b1;
      ifc.cfg_start_hz = 32'd1000000;
      ifc.cfg_stop_hz  = 32'd2000000;
      ifc.cfg_step_hz  = 32'd1000;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         ifc.cfg_valid = 1'b0;
      end
      reset = 1'b1;
      #1;
      check_eq("midop_reset", 128'(obs_vec()), 128'(vec(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0)));
      repeat (2) @(negedge clk);
      check_eq("midop_reset_held", 128'(obs_vec()), 128'(vec(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0)));
      reset = 1'b0;
      m_start = 32'd0; m_stop = 32'd0; m_step = 32'd0; m_rst = 1'b1; m_err = 1'b0;
      @(negedge clk);
      check_eq("midop_release", 128'(obs_vec()), 128'(vec(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0)));
      run_req(32'd20000000, 32'd21000000, 32'd12345, 1'b0);
      idle_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sweep_cfg_loader.md
# sweep_cfg_loader

Front-end for the DDS sweep phase-increment generator. It accepts a sweep request in hertz (start, stop, step) and converts each value to a 32-bit DDS phase increment with a sequential shift-add multiplier. It validates the result and drives the generator's `start_freq` / `stop_freq` / `step_size` inputs. New values are committed atomically, with the generator held in reset so that it restarts cleanly at the new start frequency.

## Interface
- `SCALE`, 3655519 — phase-increment scale, round(2^32/fs · 2^FRAC); the default is for fs = 77 MHz.
- `FRAC`, 16 — fractional bits in `SCALE`.
- `RST_CYCLES`, 4 — number of cycles `sweep_rst` is held high on each commit (≥1).
- `clk` in 1 — the single clock.
- `reset` in 1 — asynchronous, active-high.
- `cfg_valid` in 1 — request valid.
- `cfg_ready` out 1 — loader idle and able to accept a request.
- `cfg_start_hz` in 32 — start frequency, Hz.
- `cfg_stop_hz` in 32 — stop frequency, Hz.
- `cfg_step_hz` in 32 — step size, Hz.
- `start_freq` out 32 — committed start phase increment.
- `stop_freq` out 32 — committed stop phase increment.
- `step_size` out 32 — committed step phase increment.
- `sweep_rst` out 1 — drives the generator's `reset`.
- `cfg_done` out 1 — one-cycle pulse when a request finishes, whether accepted or rejected.
- `cfg_err` out 1 — status of the last finished request; 1 = rejected.
- `busy` out 1 — equals `~cfg_ready`.

## Operation
- States: IDLE, CONV, CHECK, COMMIT_HOLD.
- **Reset values:**
  - `cfg_ready` = 0.
  - `start_freq`, `stop_freq`, `step_size` = 0.
  - `sweep_rst` = 1.
  - `cfg_done` = 0, `cfg_err` = 0, `busy` = 1.
  - State = IDLE.
- **First cycle after reset release:** `cfg_ready` = 1. `sweep_rst` stays 1 until the first successful commit completes its hold, so the generator stays idle until it is configured.
- **IDLE:**
  - `cfg_ready` = 1.
  - On `cfg_valid & cfg_ready`, capture the three Hz inputs into internal registers and go to CONV.
  - Later changes on the `cfg_*_hz` inputs are ignored.
- **CONV:**
  - Converts start, then stop, then step, one at a time.
  - Each conversion is 32 shift-add iterations of hz × SCALE into a 64-bit accumulator, one iteration per cycle.
  - Result = product[FRAC+31:FRAC], truncated.
  - If any product bit above FRAC+31 is set, the result saturates to 32'hFFFFFFFF.
  - Results go to shadow registers; the outputs do not change during CONV.
- **CHECK (one cycle):** reject if the step increment is 0, or if the stop increment is less than the start increment.
  - On reject: `cfg_err` ← 1, `cfg_done` pulses, go to IDLE. Committed outputs and `sweep_rst` are unchanged.
  - On accept: go to COMMIT_HOLD.
- **COMMIT_HOLD:**
  - On entry edge: all three outputs load from the shadow registers simultaneously, and `sweep_rst` ← 1.
  - Hold for RST_CYCLES cycles.
  - At the end: `sweep_rst` ← 0, `cfg_err` ← 0, `cfg_done` pulses, go to IDLE.
- **Reset mid-operation:** asynchronously restores all reset values. A request in progress is discarded, with no `cfg_done`.
- **Saturation:** a saturated value is not itself an error. Only the CHECK rules reject a request.

## Timing
- Handshake edge = cycle 0.
- CONV occupies cycles 1–96:
  - start: cycles 1–32
  - stop: cycles 33–64
  - step: cycles 65–96
- CHECK is cycle 97.
- **Reject:** `cfg_done` = 1 and `cfg_err` = 1 in cycle 98; `cfg_ready` = 1 in cycle 98.
- **Accept:**
  - Outputs are updated and `sweep_rst` = 1 from cycle 98 through 97+RST_CYCLES.
  - In cycle 98+RST_CYCLES: `sweep_rst` = 0, `cfg_done` = 1, `cfg_ready` = 1.
- `cfg_ready` is 0 from cycle 1 until the `cfg_done` cycle; `cfg_valid` is ignored while `cfg_ready` is 0.
- A new request may be accepted in the same cycle that `cfg_done` is high.
- Committed outputs are stable whenever `sweep_rst` = 0. They change only on the COMMIT_HOLD entry edge.

## Test plan
- **Single accepted request:** reset, then request (start 16000000, stop 17000000, step 100000).
  - Expect `step_size` = 32'h00551C97 and `start_freq` = (16000000·3655519)>>16.
  - Expect `cfg_done` at cycle 102 (RST_CYCLES = 4) with `cfg_err` = 0.
  - Expect `sweep_rst` to fall at cycle 102.
- **Zero step:** step 0 → `cfg_err` = 1 and `cfg_done` at cycle 98. Outputs stay at their previous values and `sweep_rst` does not pulse.
- **Stop below start:** stop 1000000, start 2000000 → rejected. A following valid request clears `cfg_err` at its `cfg_done`.
- **Saturation:** start = stop = 32'hFFFFFFFF, step 1 → `start_freq` = `stop_freq` = 32'hFFFFFFFF, request accepted.
- **Reset and ignored inputs:**
  - Assert `reset` during cycle 50 of CONV → all outputs return to reset values immediately, no `cfg_done`, and `cfg_ready` = 1 one cycle after release.
  - Hold `cfg_valid` high and change the `cfg_*_hz` inputs while busy → no second capture; the results match the originally captured values.
- **Back-to-back:** present a second request exactly in the first request's `cfg_done` cycle → it is accepted. Outputs change only at its COMMIT_HOLD entry, with a new RST_CYCLES-long `sweep_rst` pulse.
